// File: rtl/mem_pkg.sv
// Shared definitions for the memory initiator: FSM state encoding and the
// default geometry/timing of the attached memory.
package mem_pkg;

   localparam int DEF_MEM_DEPTH   = 512;
   localparam int DEF_WAIT_CYCLES = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

endpackage

// File: rtl/mem_initiator_if.sv
// CPU request/response channel plus memory strobe bus of the initiator.
// The master modport is the initiator's view; slave is the CPU/memory side.
interface mem_initiator_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_data_out;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_address, mem_data_in, mem_read, mem_write
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_data_out,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_address, mem_data_in, mem_read, mem_write
   );

endinterface

// File: rtl/mem_initiator.sv
// Single-outstanding CPU-to-memory initiator: holds the read/write strobe for
// WAIT_CYCLES+1 cycles, releases for one cycle, then presents the response.
module mem_initiator
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int MEM_DEPTH   = DEF_MEM_DEPTH
) (
   input  logic            clk,
   input  logic            clr,
   mem_initiator_if.master bus
);

   localparam logic [1:0]  S_IDLE    = ST_IDLE;
   localparam logic [1:0]  S_STROBE  = ST_STROBE;
   localparam logic [1:0]  S_RELEASE = ST_RELEASE;
   localparam logic [1:0]  S_RESP    = ST_RESP;
   localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
   localparam logic [31:0] DEPTH_W   = 32'(MEM_DEPTH);

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_mem_read;
   logic        r_mem_write;
   logic [31:0] r_mem_address;
   logic [31:0] r_mem_data_in;
   logic        r_rsp_valid;
   logic        r_rsp_err;
   logic [31:0] r_rsp_rdata;

   logic        w_req_ready;
   logic        w_accept;
   logic        w_in_range;

   // Ready depends only on state and reset, never on rsp_ready.
   assign w_req_ready = (r_state == S_IDLE) && clr;
   assign w_accept    = bus.req_valid && w_req_ready;
   assign w_in_range  = bus.req_addr < DEPTH_W;

   always_ff @(posedge clk) begin
      // NOTE: every register here, datapath included, is cleared so a transaction
      // cut short by reset leaves no stale address, data or response behind.
      if (!clr) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_address <= '0;
         r_mem_data_in <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_rdata   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mem_address <= bus.req_addr;
                  r_mem_data_in <= bus.req_wdata;
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= !w_in_range;
                  r_cnt         <= WAIT_LOAD;
                  if (w_in_range) begin
                     r_mem_read  <= !bus.req_we;
                     r_mem_write <= bus.req_we;
                     r_state     <= S_STROBE;
                  end else begin
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_RESP;
                  end
               end
            end
            S_STROBE: begin
               if (r_cnt == 4'd0) begin
                  // Last strobe cycle: the read strobe doubles as the latched load flag.
                  if (r_mem_read) begin
                     r_rsp_rdata <= bus.mem_data_out;
                  end
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_state     <= S_RELEASE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RELEASE: begin
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rsp_rdata;
   assign bus.rsp_err     = r_rsp_err;
   assign bus.mem_address = r_mem_address;
   assign bus.mem_data_in = r_mem_data_in;
   assign bus.mem_read    = r_mem_read;
   assign bus.mem_write   = r_mem_write;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a WAIT_CYCLES=1 instance driven from a
// vector table and a WAIT_CYCLES=0 instance for the back-to-back sequence.
module tb_mem_initiator;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          hold;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   logic        clk = 1'b0;
   logic        clr;
   logic        sel;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_ready;
   logic        pre_we;
   logic [8:0]  pre_addr;
   logic [31:0] pre_data;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem0 [512];
   logic [31:0] mem1 [512];

   mem_initiator_if if0 ();
   mem_initiator_if if1 ();

   always #5 clk = ~clk;

   mem_initiator #(.WAIT_CYCLES(1), .MEM_DEPTH(512)) u_dut0 (
      .clk (clk),
      .clr (clr),
      .bus (if0.master)
   );

   mem_initiator #(.WAIT_CYCLES(0), .MEM_DEPTH(512)) u_dut1 (
      .clk (clk),
      .clr (clr),
      .bus (if1.master)
   );

   assign if0.req_valid = req_valid & ~sel;
   assign if1.req_valid = req_valid & sel;
   assign if0.req_we    = req_we;
   assign if1.req_we    = req_we;
   assign if0.req_addr  = req_addr;
   assign if1.req_addr  = req_addr;
   assign if0.req_wdata = req_wdata;
   assign if1.req_wdata = req_wdata;
   assign if0.rsp_ready = rsp_ready;
   assign if1.rsp_ready = rsp_ready;

   // Combinational-read, clocked-write memory models.
   assign if0.mem_data_out = mem0[if0.mem_address[8:0]];
   assign if1.mem_data_out = mem1[if1.mem_address[8:0]];

   always @(posedge clk) begin
      if (pre_we) mem0[pre_addr] <= pre_data;
      else if (if0.mem_write) mem0[if0.mem_address[8:0]] <= if0.mem_data_in;
   end

   always @(posedge clk) begin
      if (if1.mem_write) mem1[if1.mem_address[8:0]] <= if1.mem_data_in;
   end

   logic        w_req_ready, w_rsp_valid, w_rsp_err, w_mem_read, w_mem_write;
   logic [31:0] w_rsp_rdata, w_mem_address, w_mem_data_in;

   assign w_req_ready   = sel ? if1.req_ready   : if0.req_ready;
   assign w_rsp_valid   = sel ? if1.rsp_valid   : if0.rsp_valid;
   assign w_rsp_err     = sel ? if1.rsp_err     : if0.rsp_err;
   assign w_rsp_rdata   = sel ? if1.rsp_rdata   : if0.rsp_rdata;
   assign w_mem_read    = sel ? if1.mem_read    : if0.mem_read;
   assign w_mem_write   = sel ? if1.mem_write   : if0.mem_write;
   assign w_mem_address = sel ? if1.mem_address : if0.mem_address;
   assign w_mem_data_in = sel ? if1.mem_data_in : if0.mem_data_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Starts on a falling edge; ends on the falling edge after the response handshake.
   task automatic run_txn(input vec_t v, input string tag);
      int          lat, nrd, nwr;
      logic        bad, hold_bad, got_rv, err;
      logic [31:0] rd;
      lat = 0; nrd = 0; nwr = 0;
      bad = 1'b0; hold_bad = 1'b0; got_rv = 1'b0; err = 1'b0; rd = '0;
      check({tag, "_ready_before"}, 32'(w_req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = v.we;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int c = 1; c <= 40 && !got_rv; c++) begin
         if (w_mem_read) nrd++;
         if (w_mem_write) nwr++;
         if (w_mem_read && w_mem_write) bad = 1'b1;
         if ((w_mem_read || w_mem_write) && w_mem_address !== v.addr) bad = 1'b1;
         if (w_rsp_valid) begin
            got_rv = 1'b1;
            lat    = c;
            rd     = w_rsp_rdata;
            err    = w_rsp_err;
         end else begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         if (!w_rsp_valid || w_rsp_rdata !== rd || w_rsp_err !== err || w_req_ready)
            hold_bad = 1'b1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_latency"},     32'(lat),         32'(v.exp_lat));
      check({tag, "_rdata"},       rd,               v.exp_rdata);
      check({tag, "_err"},         32'(err),         32'(v.exp_err));
      check({tag, "_read_cycles"}, 32'(nrd),         32'(v.exp_rd));
      check({tag, "_write_cycles"},32'(nwr),         32'(v.exp_wr));
      check({tag, "_strobe_bus"},  32'(bad),         32'd0);
      check({tag, "_hold_stable"}, 32'(hold_bad),    32'd0);
      check({tag, "_ready_after"}, 32'(w_req_ready), 32'd1);
      check({tag, "_rsp_dropped"}, 32'(w_rsp_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [8];
      logic [7:0]  s_rdy, s_wr, s_rd, s_rv;
      logic [31:0] rd7;
      int          seen_rv;

      // WAIT_CYCLES=1: strobe 2 cycles, response in cycle N+4; errors in N+1.
      vecs[0] = '{1'b1, 32'h87,       32'h43,       0, 32'h0,        1'b0, 4, 0, 2};
      vecs[1] = '{1'b0, 32'h95,       32'h0,        0, 32'hD,        1'b0, 4, 2, 0};
      vecs[2] = '{1'b0, 32'h200,      32'h0,        0, 32'h0,        1'b1, 1, 0, 0};
      vecs[3] = '{1'b0, 32'h87,       32'h0,        4, 32'h43,       1'b0, 4, 2, 0};
      vecs[4] = '{1'b1, 32'h1FF,      32'hDEADBEEF, 0, 32'h0,        1'b0, 4, 0, 2};
      vecs[5] = '{1'b0, 32'h1FF,      32'h0,        0, 32'hDEADBEEF, 1'b0, 4, 2, 0};
      vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'h1234,     2, 32'h0,        1'b1, 1, 0, 0};
      vecs[7] = '{1'b0, 32'h1FF,      32'h0,        0, 32'hDEADBEEF, 1'b0, 4, 2, 0};

      clr = 1'b0; sel = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      pre_we = 1'b1; pre_addr = 9'h095; pre_data = 32'hD;
      repeat (2) @(posedge clk);
      @(negedge clk);
      pre_we = 1'b0;
      check("rst_req_ready",   32'(w_req_ready), 32'd0);
      check("rst_rsp_valid",   32'(w_rsp_valid), 32'd0);
      check("rst_mem_read",    32'(w_mem_read),  32'd0);
      check("rst_mem_write",   32'(w_mem_write), 32'd0);
      check("rst_mem_address", w_mem_address,    32'd0);
      check("rst_mem_data_in", w_mem_data_in,    32'd0);
      check("rst_rsp_rdata",   w_rsp_rdata,      32'd0);
      check("rst_rsp_err",     32'(w_rsp_err),   32'd0);
      clr = 1'b1;
      #1;
      check("rst_release_ready", 32'(w_req_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i], $sformatf("v%0d", i));
      end
      check("model_word_0x87", mem0[9'h087], 32'h43);

      // Reset in the second strobe cycle of a store to 0x2B.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2B; req_wdata = 32'h5A5A0001;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("midrst_strobe1", 32'(w_mem_write), 32'd1);
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_mem_write",   32'(w_mem_write), 32'd0);
      check("midrst_mem_read",    32'(w_mem_read),  32'd0);
      check("midrst_rsp_valid",   32'(w_rsp_valid), 32'd0);
      check("midrst_mem_address", w_mem_address,    32'd0);
      check("midrst_mem_data_in", w_mem_data_in,    32'd0);
      check("midrst_rsp_rdata",   w_rsp_rdata,      32'd0);
      check("midrst_rsp_err",     32'(w_rsp_err),   32'd0);
      check("midrst_req_ready",   32'(w_req_ready), 32'd0);
      clr = 1'b1;
      seen_rv = 0;
      for (int c = 0; c < 6; c++) begin
         if (w_rsp_valid) seen_rv++;
         @(posedge clk);
         @(negedge clk);
      end
      check("midrst_no_response", 32'(seen_rv), 32'd0);
      // The first strobe cycle's edge already committed the store to the model.
      run_txn('{1'b0, 32'h2B, 32'h0, 0, 32'h5A5A0001, 1'b0, 4, 2, 0}, "after_rst");

      // WAIT_CYCLES=0 instance: store then load of 0x33 with req_valid held high.
      sel = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h33; req_wdata = 32'h77AA;
      rsp_ready = 1'b1;
      rd7 = '0;
      for (int c = 0; c < 8; c++) begin
         s_rdy[c] = w_req_ready;
         s_wr[c]  = w_mem_write;
         s_rd[c]  = w_mem_read;
         s_rv[c]  = w_rsp_valid;
         if (c == 7) rd7 = w_rsp_rdata;
         if (c == 1) req_we = 1'b0;
         if (c == 7) req_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      check("b2b_req_ready_trace", 32'(s_rdy), 32'h11);
      check("b2b_write_trace",     32'(s_wr),  32'h02);
      check("b2b_read_trace",      32'(s_rd),  32'h20);
      check("b2b_rsp_valid_trace", 32'(s_rv),  32'h88);
      check("b2b_load_data",       rd7,        32'h77AA);
      check("b2b_model_word_0x33", mem1[9'h033], 32'h77AA);
      check("b2b_idle_after",      32'(w_req_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
